// File: rtl/sram_req_arbiter_pkg.sv
// Shared sram-like field widths, size encodings and owner tag encodings
// for the two-to-one sram request arbiter.
package sram_req_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  // Owner of an accepted request, stored in the in-order tag FIFO.
  typedef enum logic {
    TAG_INST = 1'b0,
    TAG_DATA = 1'b1
  } tag_e;

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order 1-bit owner FIFO; supports push and pop in the same cycle.
module sram_req_arbiter_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_r == (PTR_W+1)'(DEPTH));
  assign empty   = (count_r == (PTR_W+1)'(0));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Tag storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-to-one sram-like arbiter: data-first selection with address-phase
// lock, owner tag FIFO, and in-order response demux to the two requesters.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_req,
  input  logic                   inst_wr,
  input  logic [1:0]             inst_size,
  input  logic [31:0]            inst_addr,
  input  logic [3:0]             inst_wstrb,
  input  logic [31:0]            inst_wdata,
  output logic                   inst_addr_ok,
  output logic                   inst_data_ok,
  output logic [31:0]            inst_rdata,
  input  logic                   data_req,
  input  logic                   data_wr,
  input  logic [1:0]             data_size,
  input  logic [31:0]            data_addr,
  input  logic [3:0]             data_wstrb,
  input  logic [31:0]            data_wdata,
  output logic                   data_addr_ok,
  output logic                   data_data_ok,
  output logic [31:0]            data_rdata,
  output logic                   mem_req,
  output logic                   mem_wr,
  output logic [1:0]             mem_size,
  output logic [31:0]            mem_addr,
  output logic [3:0]             mem_wstrb,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_addr_ok,
  input  logic                   mem_data_ok,
  input  logic [31:0]            mem_rdata,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                   err
);

  tag_e sel;
  tag_e lock_owner_r;
  logic lock_r;
  logic err_r;
  logic sel_data;
  logic accept;
  logic rsp_valid;
  logic fifo_full;
  logic fifo_empty;
  logic head_owner;

  // Selection: a stalled address phase keeps its owner, otherwise data wins.
  always_comb begin
    sel = TAG_INST;
    if (lock_r) begin
      sel = lock_owner_r;
    end else if (data_req) begin
      sel = TAG_DATA;
    end else begin
      sel = TAG_INST;
    end
  end

  assign sel_data  = (sel == TAG_DATA);
  assign mem_req   = (inst_req | data_req) & ~fifo_full & ~reset;
  assign mem_wr    = sel_data ? data_wr    : inst_wr;
  assign mem_size  = sel_data ? data_size  : inst_size;
  assign mem_addr  = sel_data ? data_addr  : inst_addr;
  assign mem_wstrb = sel_data ? data_wstrb : inst_wstrb;
  assign mem_wdata = sel_data ? data_wdata : inst_wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept & sel_data;

  // Responses go only to the owner at the FIFO head; empty-FIFO ones drop.
  assign rsp_valid    = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = rsp_valid & (head_owner == TAG_INST);
  assign data_data_ok = rsp_valid & (head_owner == TAG_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err          = err_r;

  sram_req_arbiter_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (mem_data_ok),
    .din   (sel),
    .dout  (head_owner),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (inflight)
  );

  // Lock the owner while its address phase is stalled; release on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_r       <= 1'b0;
      lock_owner_r <= TAG_INST;
    end else if (mem_req & ~mem_addr_ok) begin
      lock_r       <= 1'b1;
      lock_owner_r <= sel;
    end else if (accept) begin
      lock_r       <= 1'b0;
      lock_owner_r <= lock_owner_r;
    end else begin
      lock_r       <= lock_r;
      lock_owner_r <= lock_owner_r;
    end
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (mem_data_ok & fifo_empty) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter that lets the instruction-fetch and data-access sram-like request ports share one sram-like memory port, between the pipeline (IF/EX/MEM) and the memory bridge. It picks which requester drives each address phase, holds that choice while an address phase is stalled, and records the owner of every accepted request in an in-order tag FIFO. Each returning `data_ok`/`rdata` goes to the correct requester, so the MEM stage's outstanding-count logic sees only its own responses.

## Interface
- `DEPTH`, 4: maximum outstanding (accepted, not yet answered) requests; power of two, ≥2.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `inst_req` / `data_req` in 1: request valid from fetch / data side.
- `inst_wr` / `data_wr` in 1: write request.
- `inst_size` / `data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `inst_addr` / `data_addr` in 32: byte address.
- `inst_wstrb` / `data_wstrb` in 4: byte-write strobes.
- `inst_wdata` / `data_wdata` in 32: write data.
- `inst_addr_ok` / `data_addr_ok` out 1: address phase accepted for that requester.
- `inst_data_ok` / `data_data_ok` out 1: response for that requester.
- `inst_rdata` / `data_rdata` out 32: read data, equal to `mem_rdata`.
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_addr[31:0]`, `mem_wstrb[3:0]`, `mem_wdata[31:0]` out: muxed request to memory.
- `mem_addr_ok` in 1, `mem_data_ok` in 1, `mem_rdata` in 32: memory handshake.
- `inflight` out log2(DEPTH)+1: current FIFO occupancy.
- `err` out 1: sticky flag, set when `mem_data_ok` arrives with the FIFO empty.

## Operation
- **Selection, when unlocked:** data has fixed priority over inst. MEM holds older instructions, and giving it priority avoids deadlock.
- **Locking:** if `mem_req & ~mem_addr_ok` in a cycle, the current selection is locked. The same requester stays selected until its `mem_addr_ok`.
  - While locked, the other requester is not granted, even data over inst.
  - The lock clears in the cycle of the accepting `mem_addr_ok`.
- **Request gating:** `mem_req = (inst_req | data_req) & ~full & ~reset`. All other `mem_*` fields are muxed from the selected requester.
- **Address handshake:** `sel_addr_ok = mem_addr_ok & mem_req & selected`. The unselected requester's `addr_ok` is 0.
- **Push:** on `mem_req & mem_addr_ok`, push owner tag (1 = data, 0 = inst).
- **Pop:** on `mem_data_ok` with the FIFO non-empty, pop the head. Route `data_ok` to the head owner only; the other `data_ok` is 0.
- **Simultaneous push and pop:** both happen; occupancy is unchanged and pointers wrap modulo DEPTH.
- **Full:** `mem_req` = 0 and both `addr_ok` = 0. The lock state is retained.
- **Empty:** `mem_data_ok` is dropped (no `data_ok` out) and sets `err`.
- **Reset mid-operation:** the FIFO is emptied and the lock and `err` cleared. Responses to pre-reset requests that arrive after reset hit the empty FIFO and set `err`. The system bridge must be reset together with this block.

## Timing
- Zero-cycle combinational paths: req → `mem_req`, `mem_addr_ok` → requester `addr_ok`, `mem_data_ok`/`mem_rdata` → requester `data_ok`/`rdata`.
- Registered state: FIFO, pointers, lock bit with locked owner, `err`. All update on the rising clk edge.
- **Reset values:** `inflight` = 0, `err` = 0, lock = 0. All `*_addr_ok`, `*_data_ok` and `mem_req` are 0 while reset is high.
- A request accepted in cycle N may receive `data_ok` in cycle N+1 or later, never in cycle N.
- Throughput: one address phase per cycle, one response per cycle.

## Structure
- Shared package/macro header holds the sram-like field widths (size encodings, strobe width) and the tag encodings `TAG_INST = 0`, `TAG_DATA = 1`.
- One natural sub-module: `tag_fifo`. It is a synchronous 1-bit-wide FIFO of DEPTH entries with push/pop/full/empty/count and supports simultaneous push and pop.
- The arbiter top holds the select and lock logic and the response demux.

## Test plan
1. **Single inst read:** `inst_req` with addr 0x1c000000, `mem_addr_ok` = 1 in cycle 0, `mem_data_ok` in cycle 2 with rdata 0x12345678. Expect `inst_addr_ok` in cycle 0, `inst_data_ok` with 0x12345678 in cycle 2, `data_data_ok` = 0 throughout, `inflight` 1 → 0.
2. **Simultaneous requests:** both req in cycle 0, `mem_addr_ok` = 1 every cycle. Expect data accepted in cycle 0 and inst in cycle 1. Two responses return in order and route data then inst.
3. **Lock:** `inst_req` alone with `mem_addr_ok` = 0 for 3 cycles, `data_req` rises in cycle 1, `mem_addr_ok` = 1 in cycle 3. Expect `mem_addr` = inst address during cycles 0–3 and inst accepted in cycle 3. Data is accepted in cycle 4.
4. **Full:** with DEPTH = 4, issue 4 accepted requests with no responses. Expect `inflight` = 4 and `mem_req` = 0 despite a pending req. After one `mem_data_ok`, `mem_req` reasserts the next cycle.
5. **Push and pop in the same cycle:** at `inflight` = 2, expect `inflight` to stay 2 and correct owner routing across pointer wrap. Run at least 10 transactions alternating owners.
6. **Stray response:** `mem_data_ok` with the FIFO empty, and also the first response after a mid-transaction reset. Expect no requester `data_ok` and `err` = 1 held until reset.
